po_clk_div: RTL and testbench

Clock-divider and ready-generator block (`po`) that derives a slow square-wave clock `clk2` from the system clock. It also raises a sticky ready/release flag `rr` once a programmable number of `clk2` periods has elapsed after reset. It sits at the top of the design's clocking path and gates start-up of downstream logic running from `clk2`.

---
 rtl/po_clk_div.sv | 59 +++++
 tb/tb_po_clk_div.sv | 123 ++++++++++++
 2 files changed

// File: rtl/po_clk_div.sv
// Clock divider: produces clk2 with a period of 2*DIV_HALF clk cycles, and a ready
// flag rr that asserts on the RR_DELAY-th clk2 rise. With PO_RR_PULSE_EN, rr is a one-cycle pulse.
module po_clk_div #(
  parameter int unsigned DIV_HALF = 4,
  parameter int unsigned RR_DELAY = 16
) (
  input  logic clk,
  input  logic rst,
  output logic clk2,
  output logic rr
);

  localparam int unsigned CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int unsigned NW = $clog2(RR_DELAY + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV_HALF - 1);
  localparam logic [NW-1:0] RISE_MAX = NW'(RR_DELAY);
  localparam logic [NW-1:0] RISE_PRE = NW'(RR_DELAY - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] nrise_q, nrise_d;
  logic          clk2_q, clk2_d;
  logic          rr_q, rr_d;
  logic          wrap, rise, hit;

  always_comb begin
    wrap    = (cnt_q == CNT_MAX);
    rise    = wrap && !clk2_q;
    // The edge that completes the final counted rise is the only edge that raises rr.
    hit     = rise && (nrise_q == RISE_PRE);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    clk2_d  = wrap ? ~clk2_q : clk2_q;
    nrise_d = nrise_q;
    if (rise && (nrise_q < RISE_MAX)) nrise_d = nrise_q + 1'b1;
`ifdef PO_RR_PULSE_EN
    rr_d    = hit;
`else
    rr_d    = rr_q | hit;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      clk2_q  <= 1'b0;
      nrise_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clk2_q  <= clk2_d;
      nrise_q <= nrise_d;
      rr_q    <= rr_d;
    end
  end

  assign clk2 = clk2_q;
  assign rr   = rr_q;

endmodule

// File: tb/tb_po_clk_div.sv
// Scoreboard bench for po_clk_div: checks a default instance and a DIV_HALF=1/RR_DELAY=1 instance.
// The driver pushes the expected outputs for every edge, and a monitor compares them.
module tb_po_clk_div;

  localparam int DA = 4, RA = 16;
  localparam int DB = 1, RB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk2_a, rr_a, clk2_b, rr_b;

  always #5 clk = ~clk;

  po_clk_div #(.DIV_HALF(DA), .RR_DELAY(RA)) u_a (
    .clk(clk), .rst(rst), .clk2(clk2_a), .rr(rr_a)
  );
  po_clk_div #(.DIV_HALF(DB), .RR_DELAY(RB)) u_b (
    .clk(clk), .rst(rst), .clk2(clk2_b), .rr(rr_b)
  );

  typedef struct {
    int   edge_n;
    logic clk2_a, rr_a, clk2_b, rr_b;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit driver_done = 1'b0;

  // Expected outputs after edge n, taken from the edge-timing formulas.
  function automatic exp_t expect_at(input int n, input bit in_rst);
    exp_t e;
    int rr_edge_a, rr_edge_b;
    e.edge_n = in_rst ? -1 : n;
    rr_edge_a = (2*RA - 1) * DA;
    rr_edge_b = (2*RB - 1) * DB;
    if (in_rst) begin
      e.clk2_a = 1'b0; e.rr_a = 1'b0; e.clk2_b = 1'b0; e.rr_b = 1'b0;
    end else begin
      e.clk2_a = logic'((n / DA) % 2);
      e.clk2_b = logic'((n / DB) % 2);
`ifdef PO_RR_PULSE_EN
      e.rr_a = (n == rr_edge_a);
      e.rr_b = (n == rr_edge_b);
`else
      e.rr_a = (n >= rr_edge_a);
      e.rr_b = (n >= rr_edge_b);
`endif
    end
    return e;
  endfunction

  int edge_cnt = 0;

  task automatic step(input logic r);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    if (r) edge_cnt = 0;
    else   edge_cnt = edge_cnt + 1;
    exp_q.push_back(expect_at(edge_cnt, r));
  endtask

  task automatic cmp(input string name, input int n, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%b exp=%b", name, n, got, exp);
    end
  endtask

  // The monitor samples 1 time unit after each edge, once the driver has pushed that edge's entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("clk2_a", e.edge_n, clk2_a, e.clk2_a);
        cmp("rr_a",   e.edge_n, rr_a,   e.rr_a);
        cmp("clk2_b", e.edge_n, clk2_b, e.clk2_b);
        cmp("rr_b",   e.edge_n, rr_b,   e.rr_b);
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 10; i++) step(1'b1);
    // Reassert reset at edge 130 for one edge, then run again.
    for (int i = 0; i < 129; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 300; i++) step(1'b0);
    driver_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!driver_done && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (!driver_done) begin
      checks++; errors++;
      $display("FAIL driver_timeout got=%0d cycles exp=<2000", budget);
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
